// File: rtl/seg_arb_pkg.sv
// Shared types and widths for the seven-segment display arbiter.
package seg_arb_pkg;

    localparam int unsigned DISP_W = 16;

    typedef logic [DISP_W-1:0] disp_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        SLOT = 1'b1
    } seg_arb_state_t;

endpackage : seg_arb_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request searching upward
// from last+1, wrapping around to last itself.
module rr_picker #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int unsigned pos;

    // Scan from the farthest offset down to the nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(last) + N_REQ - k) % N_REQ;
            if (req[IDX_W'(pos)]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule : rr_picker

// File: rtl/seg_display_arbiter.sv
// Round-robin time-sharing of the 16-bit seven-segment display word among
// N_REQ requesters, one fixed-length slot per grant.
// Optional macro SEG_ARB_LIVE_EN: reload disp_data from the owner's word
// every slot cycle instead of capturing it only at slot start.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter  int unsigned N_REQ       = 4,
    parameter  int unsigned HOLD_CYCLES = 50_000_000,
    localparam int unsigned IDX_W       = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  disp_word_t       req_data [N_REQ],
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output disp_word_t       disp_data,
    output logic [IDX_W-1:0] disp_src,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    seg_arb_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] last;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req   (req),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Slot FSM; disp_src doubles as the current owner index while in SLOT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= IDX_W'(N_REQ - 1);
            grant     <= '0;
            done      <= '0;
            disp_data <= '0;
            disp_src  <= '0;
            busy      <= 1'b0;
        end else begin
            done <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= SLOT;
                        cnt       <= '0;
                        last      <= pick_idx;
                        grant     <= N_REQ'(1) << pick_idx;
                        disp_src  <= pick_idx;
                        disp_data <= req_data[pick_idx];
                        busy      <= 1'b1;
                    end
                end
                SLOT: begin
                    if (!req[disp_src]) begin
                        // Owner withdrew: abort without done, arbitrate next edge.
                        state <= IDLE;
                        cnt   <= '0;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        done[disp_src] <= 1'b1;
                        if (pick_found) begin
                            cnt       <= '0;
                            last      <= pick_idx;
                            grant     <= N_REQ'(1) << pick_idx;
                            disp_src  <= pick_idx;
                            disp_data <= req_data[pick_idx];
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
`ifdef SEG_ARB_LIVE_EN
                        disp_data <= req_data[disp_src];
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : seg_display_arbiter

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with N_REQ=4, HOLD_CYCLES=4.
module tb_seg_display_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned HOLD  = 4;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic [15:0] data;
        logic [1:0]  src;
        logic        busy;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_data [N_REQ];
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [15:0] disp_data;
    logic [1:0]  disp_src;
    logic        busy;

    int n_vec;
    int n_bad;
    vec_t vq[$];

    seg_display_arbiter #(
        .N_REQ       (N_REQ),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .done      (done),
        .disp_data (disp_data),
        .disp_src  (disp_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] eg, input logic [3:0] ed,
                       input logic [15:0] edata, input logic [1:0] esrc, input logic eb);
        n_vec++;
        if (grant !== eg || done !== ed || disp_data !== edata || disp_src !== esrc || busy !== eb) begin
            n_bad++;
            $display("FAIL %s: got grant=%b done=%b data=%h src=%0d busy=%b, want grant=%b done=%b data=%h src=%0d busy=%b",
                     name, grant, done, disp_data, disp_src, busy, eg, ed, edata, esrc, eb);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [3:0] d,
                       input logic [15:0] data, input logic [1:0] s, input logic b);
        vec_t v;
        v.req = r; v.grant = g; v.done = d; v.data = data; v.src = s; v.busy = b;
        vq.push_back(v);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            req = vq[i].req;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), vq[i].grant, vq[i].done, vq[i].data, vq[i].src, vq[i].busy);
        end
    endtask

    initial begin
        int part_a;
        logic [15:0] live_exp;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req   = '0;
        req_data[0] = 16'h1234;
        req_data[1] = 16'h1111;
        req_data[2] = 16'h2222;
        req_data[3] = 16'h3333;

        // Part A: single requester, 3-way rotation, owner abort.
        add(4'b1001, 4'b0001, 4'b0000, 16'h1234, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b0001, 4'b0001, 4'b0000, 16'h1234, 2'd0, 1'b1);
        add(4'b0001, 4'b0001, 4'b0001, 16'h1234, 2'd0, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 16'h1234, 2'd0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 16'h1234, 2'd0, 1'b0);
        add(4'b1011, 4'b0010, 4'b0000, 16'h1111, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b1011, 4'b0010, 4'b0000, 16'h1111, 2'd1, 1'b1);
        add(4'b1011, 4'b1000, 4'b0010, 16'h3333, 2'd3, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b1011, 4'b1000, 4'b0000, 16'h3333, 2'd3, 1'b1);
        add(4'b1011, 4'b0001, 4'b1000, 16'h1234, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b1011, 4'b0001, 4'b0000, 16'h1234, 2'd0, 1'b1);
        add(4'b1011, 4'b0010, 4'b0001, 16'h1111, 2'd1, 1'b1);
        add(4'b1011, 4'b0010, 4'b0000, 16'h1111, 2'd1, 1'b1);
        add(4'b1001, 4'b0000, 4'b0000, 16'h1111, 2'd1, 1'b0);
        add(4'b1001, 4'b1000, 4'b0000, 16'h3333, 2'd3, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 16'h3333, 2'd3, 1'b0);
        part_a = vq.size();

        // Part B: requester 2 alone, back-to-back slots, then release.
        for (int i = 0; i < 3; i++) add(4'b0100, 4'b0100, 4'b0000, 16'h2222, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 4'b0100, 16'h2222, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++) add(4'b0100, 4'b0100, 4'b0000, 16'h2222, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 4'b0100, 16'h2222, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 16'h2222, 2'd2, 1'b0);

        #12;
        chk("reset_state", 4'b0000, 4'b0000, 16'h0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        #4;

        run(0, part_a);

        // Asynchronous reset in the second slot cycle.
        req = 4'b0001;
        @(posedge clk); #1;
        chk("pre_reset_grant", 4'b0001, 4'b0000, 16'h1234, 2'd0, 1'b1);
        @(posedge clk); #1;
        chk("pre_reset_hold", 4'b0001, 4'b0000, 16'h1234, 2'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 4'b0000, 16'h0000, 2'd0, 1'b0);
        req = 4'b0100;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_grant2", 4'b0100, 4'b0000, 16'h2222, 2'd2, 1'b1);

        run(part_a, vq.size());

        // Mid-slot change of the owner's word.
`ifdef SEG_ARB_LIVE_EN
        live_exp = 16'hABCD;
`else
        live_exp = 16'h1234;
`endif
        req = 4'b0001;
        @(posedge clk); #1;
        chk("live_start", 4'b0001, 4'b0000, 16'h1234, 2'd0, 1'b1);
        @(posedge clk); #1;
        chk("live_cycle2", 4'b0001, 4'b0000, 16'h1234, 2'd0, 1'b1);
        req_data[0] = 16'hABCD;
        @(posedge clk); #1;
        chk("live_update", 4'b0001, 4'b0000, live_exp, 2'd0, 1'b1);
        req = 4'b0000;
        req_data[0] = 16'h1234;
        @(posedge clk); #1;
        chk("live_idle_hold", 4'b0000, 4'b0000, live_exp, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_seg_display_arbiter
